// File: rtl/feed_pkt_mux_pkg.sv
// -----------------------------------------------------------------------------
// feed_mux_pkg
//
// Shared types and helpers for the packet-atomic feed multiplexer.
//
// Contents:
//   MAX_CH     - largest channel count the helpers are sized for (16)
//   CH_IDX_W   - index width matching MAX_CH
//   state_t    - merger FSM state: IDLE (arbitrating) / FWD (forwarding)
//   rr_pick_t  - result of a round-robin scan: found flag + winning index
//   rr_pick()  - round-robin scan of a request vector starting at a pointer
//   popcount() - number of set bits in a request/discard vector
// -----------------------------------------------------------------------------
package feed_mux_pkg;

    localparam int MAX_CH   = 16;
    localparam int CH_IDX_W = 4;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        FWD  = 1'b1
    } state_t;

    typedef struct packed {
        logic                found;
        logic [CH_IDX_W-1:0] idx;
    } rr_pick_t;

    // Scan num_ch requesters beginning at ptr and wrapping at num_ch.
    // The first requester met along the scan wins. Entries at or above
    // num_ch are never looked at, so unused upper bits of req are ignored.
    function automatic rr_pick_t rr_pick(
        input logic [MAX_CH-1:0]   req,
        input logic [CH_IDX_W-1:0] ptr,
        input int                  num_ch
    );
        rr_pick_t            res;
        logic [CH_IDX_W-1:0] cand;
        res = '0;
        for (int i = 0; i < MAX_CH; i++) begin
            cand = CH_IDX_W'((int'(ptr) + i) % num_ch);
            if ((i < num_ch) && !res.found && req[cand]) begin
                res.found = 1'b1;
                res.idx   = cand;
            end
        end
        return res;
    endfunction

    function automatic logic [CH_IDX_W:0] popcount(input logic [MAX_CH-1:0] v);
        logic [CH_IDX_W:0] sum;
        sum = '0;
        for (int i = 0; i < MAX_CH; i++) begin
            sum = sum + {{CH_IDX_W{1'b0}}, v[i]};
        end
        return sum;
    endfunction

endpackage

// File: rtl/feed_pkt_mux_rr_arb.sv
// -----------------------------------------------------------------------------
// feed_rr_arb
//
// Round-robin priority picker used by the feed multiplexer. The pick itself
// is purely combinational; only the scan start pointer is registered.
//
// Ports:
//   clk, reset  - core clock, synchronous active-high reset (pointer -> 0)
//   i_req       - per-channel start requests (enabled, valid, SOP)
//   i_advance   - a packet from channel i_last just finished
//   i_last      - channel whose packet finished; pointer moves past it
//   o_found     - at least one channel is requesting
//   o_idx       - winning channel (valid when o_found)
//   o_ptr       - current scan start pointer (debug visibility)
// -----------------------------------------------------------------------------
module feed_rr_arb
    import feed_mux_pkg::*;
#(
    parameter int NUM_CH = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_CH-1:0]         i_req,
    input  logic                      i_advance,
    input  logic [$clog2(NUM_CH)-1:0] i_last,
    output logic                      o_found,
    output logic [$clog2(NUM_CH)-1:0] o_idx,
    output logic [$clog2(NUM_CH)-1:0] o_ptr
);

    localparam int IDX_W = $clog2(NUM_CH);

    logic [IDX_W-1:0] r_ptr;
    rr_pick_t         w_pick;

    always_comb begin
        w_pick = rr_pick(MAX_CH'(i_req), CH_IDX_W'(r_ptr), NUM_CH);
    end

    assign o_found = w_pick.found;
    assign o_idx   = IDX_W'(w_pick.idx);
    assign o_ptr   = r_ptr;

    // Pointer moves one past the channel that just completed a packet, so
    // that channel has the lowest priority in the next scan.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr <= '0;
        end else if (i_advance) begin
            if (int'(i_last) == NUM_CH - 1) begin
                r_ptr <= '0;
            end else begin
                r_ptr <= i_last + 1'b1;
            end
        end
    end

endmodule

// File: rtl/feed_pkt_mux.sv
// -----------------------------------------------------------------------------
// feed_pkt_mux
//
// Packet-atomic round-robin merger of NUM_CH Avalon-ST feed streams into one
// registered output stream (1-cycle latency, no skid buffer).
//
// Handshake: a beat moves on any interface in a cycle where valid && ready
// are both high at the rising clock edge. The output register loads when it
// is empty or out_ready is high; while out_valid && !out_ready all out_*
// fields are held unchanged.
//
// Ports:
//   clk, reset         - core clock, synchronous active-high reset
//   ch_enable          - per-channel enable (quasi-static)
//   in_valid/in_ready  - per-channel beat handshake
//   in_startofpacket   - per-channel SOP
//   in_endofpacket     - per-channel EOP
//   in_data            - channel c at [c*C_PKT_DATA_WIDTH +: C_PKT_DATA_WIDTH]
//   in_empty           - channel c at [c*C_PKT_EMPTY_WIDTH +: C_PKT_EMPTY_WIDTH]
//   in_error           - per-channel error
//   out_valid/out_ready- merged stream handshake
//   out_startofpacket, out_endofpacket, out_data, out_empty, out_error
//                      - merged beat fields
//   out_channel        - source channel of the current output beat
//   pkt_count          - forwarded packets per channel, channel c at
//                        [c*CNT_WIDTH +: CNT_WIDTH]
//   drop_count         - total discarded (stray/disabled) beats
//   o_dbg_state        - FSM state (0 = IDLE, 1 = FWD)
//   o_dbg_rr_ptr       - round-robin scan start pointer
// -----------------------------------------------------------------------------
module feed_pkt_mux
    import feed_mux_pkg::*;
#(
    parameter int NUM_CH            = 4,
    parameter int C_PKT_DATA_WIDTH  = 64,
    parameter int C_PKT_EMPTY_WIDTH = $clog2(C_PKT_DATA_WIDTH),
    parameter int CNT_WIDTH         = 32
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [NUM_CH-1:0]                   ch_enable,
    input  logic [NUM_CH-1:0]                   in_valid,
    output logic [NUM_CH-1:0]                   in_ready,
    input  logic [NUM_CH-1:0]                   in_startofpacket,
    input  logic [NUM_CH-1:0]                   in_endofpacket,
    input  logic [NUM_CH*C_PKT_DATA_WIDTH-1:0]  in_data,
    input  logic [NUM_CH*C_PKT_EMPTY_WIDTH-1:0] in_empty,
    input  logic [NUM_CH-1:0]                   in_error,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic                                out_startofpacket,
    output logic                                out_endofpacket,
    output logic [C_PKT_DATA_WIDTH-1:0]         out_data,
    output logic [C_PKT_EMPTY_WIDTH-1:0]        out_empty,
    output logic                                out_error,
    output logic [$clog2(NUM_CH)-1:0]           out_channel,
    output logic [NUM_CH*CNT_WIDTH-1:0]         pkt_count,
    output logic [CNT_WIDTH-1:0]                drop_count,
    output logic                                o_dbg_state,
    output logic [$clog2(NUM_CH)-1:0]           o_dbg_rr_ptr
);

    localparam int IDX_W = $clog2(NUM_CH);
    localparam int DW    = C_PKT_DATA_WIDTH;
    localparam int EW    = C_PKT_EMPTY_WIDTH;

    // ---------------------------------------------------------------- state
    state_t              r_state;
    state_t              w_next_state;
    logic [IDX_W-1:0]    r_grant;
    logic                r_in_pkt;     // first beat of the granted packet taken

    // --------------------------------------------------------- output stage
    logic                r_out_valid;
    logic                r_out_sop;
    logic                r_out_eop;
    logic [DW-1:0]       r_out_data;
    logic [EW-1:0]       r_out_empty;
    logic                r_out_err;
    logic [IDX_W-1:0]    r_out_channel;

    // ------------------------------------------------------------- counters
    logic [CNT_WIDTH-1:0] r_pkt_cnt [NUM_CH];
    logic [CNT_WIDTH-1:0] r_drop_cnt;

    // ---------------------------------------------------------------- wires
    logic                w_out_load;
    logic [NUM_CH-1:0]   w_start_req;
    logic                w_arb_found;
    logic [IDX_W-1:0]    w_arb_idx;
    logic [IDX_W-1:0]    w_rr_ptr;
    logic [NUM_CH-1:0]   w_in_ready;
    logic [NUM_CH-1:0]   w_drop_mask;
    logic                w_accept;
    logic                w_eop_accept;
    logic                w_g_sop;
    logic [CH_IDX_W:0]   w_drop_pop;

    assign w_out_load   = !r_out_valid || out_ready;
    assign w_start_req  = ch_enable & in_valid & in_startofpacket;
    assign w_g_sop      = in_startofpacket[r_grant];
    assign w_eop_accept = w_accept && in_endofpacket[r_grant];
    assign w_drop_pop   = popcount(MAX_CH'(w_drop_mask));

    feed_rr_arb #(
        .NUM_CH (NUM_CH)
    ) u_arb (
        .clk       (clk),
        .reset     (reset),
        .i_req     (w_start_req),
        .i_advance (w_eop_accept),
        .i_last    (r_grant),
        .o_found   (w_arb_found),
        .o_idx     (w_arb_idx),
        .o_ptr     (w_rr_ptr)
    );

    // ------------------------------------------------ FSM: state register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ---------------------------------------------------- FSM: next state
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_arb_found)  w_next_state = FWD;
            FWD:     if (w_eop_accept) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // -------------------------------------------------------- FSM: outputs
    // IDLE swallows every beat that cannot start a packet (disabled channel
    // or no SOP); an enabled SOP beat is left waiting for its grant. FWD
    // only opens the granted channel, and only when the output stage can
    // take the beat.
    always_comb begin
        w_in_ready  = '0;
        w_drop_mask = '0;
        w_accept    = 1'b0;
        case (r_state)
            IDLE: begin
                w_drop_mask = in_valid & (~ch_enable | ~in_startofpacket);
                w_in_ready  = w_drop_mask;
            end
            FWD: begin
                w_in_ready[r_grant] = w_out_load;
                w_accept            = in_valid[r_grant] && w_out_load;
            end
            default: begin
                w_in_ready = '0;
            end
        endcase
    end

    assign in_ready = w_in_ready;

    // ------------------------------------------------------- grant tracking
    // The grant is only rewritten in IDLE, so it cannot move mid-packet even
    // if the channel's enable drops.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_grant  <= '0;
            r_in_pkt <= 1'b0;
        end else begin
            if ((r_state == IDLE) && w_arb_found) begin
                r_grant  <= w_arb_idx;
                r_in_pkt <= 1'b0;
            end
            if (w_accept) begin
                r_in_pkt <= !in_endofpacket[r_grant];
            end
        end
    end

    // --------------------------------------------------------- output stage
    // A second SOP inside the granted packet is passed on as a plain beat
    // flagged with error, so downstream framing stays intact.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid   <= 1'b0;
            r_out_sop     <= 1'b0;
            r_out_eop     <= 1'b0;
            r_out_data    <= '0;
            r_out_empty   <= '0;
            r_out_err     <= 1'b0;
            r_out_channel <= '0;
        end else if (w_out_load) begin
            r_out_valid <= w_accept;
            if (w_accept) begin
                r_out_sop     <= w_g_sop && !r_in_pkt;
                r_out_eop     <= in_endofpacket[r_grant];
                r_out_data    <= in_data[int'(r_grant)*DW +: DW];
                r_out_empty   <= in_empty[int'(r_grant)*EW +: EW];
                r_out_err     <= in_error[r_grant] || (w_g_sop && r_in_pkt);
                r_out_channel <= r_grant;
            end
        end
    end

    assign out_valid         = r_out_valid;
    assign out_startofpacket = r_out_sop;
    assign out_endofpacket   = r_out_eop;
    assign out_data          = r_out_data;
    assign out_empty         = r_out_empty;
    assign out_error         = r_out_err;
    assign out_channel       = r_out_channel;

    // ------------------------------------------------------------- counters
    // Both counters wrap naturally at 2^CNT_WIDTH.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int c = 0; c < NUM_CH; c++) begin
                r_pkt_cnt[c] <= '0;
            end
            r_drop_cnt <= '0;
        end else begin
            if (w_eop_accept) begin
                r_pkt_cnt[r_grant] <= r_pkt_cnt[r_grant] + 1'b1;
            end
            r_drop_cnt <= r_drop_cnt + CNT_WIDTH'(w_drop_pop);
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_cnt
        assign pkt_count[g*CNT_WIDTH +: CNT_WIDTH] = r_pkt_cnt[g];
    end

    assign drop_count   = r_drop_cnt;
    assign o_dbg_state  = r_state;
    assign o_dbg_rr_ptr = w_rr_ptr;

endmodule

// File: tb/tb_feed_pkt_mux.sv
// -----------------------------------------------------------------------------
// tb_feed_pkt_mux
//
// Packet-level bench for feed_pkt_mux. Stimulus is queued per channel as
// whole packets; the reference model is per-channel expected-beat queues
// plus expected packet and drop counts derived from how each packet was
// built (enabled channel -> forwarded, disabled -> every beat dropped).
// -----------------------------------------------------------------------------
module tb_feed_pkt_mux;

    localparam int NUM_CH = 4;
    localparam int W      = 64;
    localparam int EW     = 6;
    localparam int CW     = 32;

    typedef struct packed {
        logic          sop;
        logic          eop;
        logic          err;
        logic [EW-1:0] empty;
        logic [W-1:0]  data;
    } beat_t;

    // ---------------------------------------------------------- clock/reset
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // ------------------------------------------------------------ DUT ports
    logic [NUM_CH-1:0]    ch_enable = '1;
    logic [NUM_CH-1:0]    in_valid = '0;
    logic [NUM_CH-1:0]    in_ready;
    logic [NUM_CH-1:0]    in_startofpacket = '0;
    logic [NUM_CH-1:0]    in_endofpacket = '0;
    logic [NUM_CH*W-1:0]  in_data = '0;
    logic [NUM_CH*EW-1:0] in_empty = '0;
    logic [NUM_CH-1:0]    in_error = '0;
    logic                 out_valid;
    logic                 out_ready = 1'b1;
    logic                 out_startofpacket;
    logic                 out_endofpacket;
    logic [W-1:0]         out_data;
    logic [EW-1:0]        out_empty;
    logic                 out_error;
    logic [1:0]           out_channel;
    logic [NUM_CH*CW-1:0] pkt_count;
    logic [CW-1:0]        drop_count;
    logic                 dbg_state;
    logic [1:0]           dbg_rr_ptr;

    feed_pkt_mux #(
        .NUM_CH            (NUM_CH),
        .C_PKT_DATA_WIDTH  (W),
        .C_PKT_EMPTY_WIDTH (EW),
        .CNT_WIDTH         (CW)
    ) dut (
        .clk               (clk),
        .reset             (rst),
        .ch_enable         (ch_enable),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .in_startofpacket  (in_startofpacket),
        .in_endofpacket    (in_endofpacket),
        .in_data           (in_data),
        .in_empty          (in_empty),
        .in_error          (in_error),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .out_startofpacket (out_startofpacket),
        .out_endofpacket   (out_endofpacket),
        .out_data          (out_data),
        .out_empty         (out_empty),
        .out_error         (out_error),
        .out_channel       (out_channel),
        .pkt_count         (pkt_count),
        .drop_count        (drop_count),
        .o_dbg_state       (dbg_state),
        .o_dbg_rr_ptr      (dbg_rr_ptr)
    );

    // ---------------------------------------------------- model/scoreboard
    beat_t         drv_q [NUM_CH][$];
    beat_t         exp_q [NUM_CH][$];
    logic [CW-1:0] exp_pkt [NUM_CH];
    logic [CW-1:0] exp_drop;
    logic [NUM_CH-1:0] en = '1;
    logic          pres [NUM_CH];
    int            acc_cnt [NUM_CH];
    int            log_ch[$];
    int            log_cyc[$];
    int            pkt_order[$];
    int            go_pct = 100;
    int            rdy_mode = 0;
    int            cyc = 0;
    int            total = 0;
    int            bad = 0;
    logic          pkt_open = 1'b0;
    int            open_ch = 0;
    logic          prev_stall = 1'b0;
    logic          prev_rst = 1'b1;
    beat_t         prev_obs;
    logic [1:0]    prev_ch;
    logic [NUM_CH-1:0] s_in_ready;
    logic          s_out_valid;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got=%0h want=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < NUM_CH; c++) exp_pkt[c] = '0;
        exp_drop = '0;
        pkt_open = 1'b0;
    endtask

    // Build one packet on channel c; stray_at >= 1 puts a second SOP there.
    task automatic gen_pkt(input int c, input int len, input int stray_at, input logic [W-1:0] base);
        beat_t b;
        beat_t e;
        for (int k = 0; k < len; k++) begin
            b.sop   = (k == 0) || (k == stray_at);
            b.eop   = (k == len - 1);
            b.err   = ($urandom_range(0, 9) == 0);
            b.empty = EW'($urandom);
            b.data  = base + W'(k);
            drv_q[c].push_back(b);
            if (en[c]) begin
                e = b;
                if (k > 0 && b.sop) begin
                    e.sop = 1'b0;
                    e.err = 1'b1;
                end
                exp_q[c].push_back(e);
            end
        end
        if (en[c]) exp_pkt[c] = exp_pkt[c] + 1'b1;
        else       exp_drop   = exp_drop + CW'(len);
    endtask

    // ---------------------------------------------------------- driver
    task automatic drive();
        beat_t b;
        in_valid = '0;
        in_startofpacket = '0;
        in_endofpacket = '0;
        in_error = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (drv_q[c].size() > 0 && (pres[c] || $urandom_range(0, 99) < go_pct)) begin
                pres[c] = 1'b1;
                b = drv_q[c][0];
                in_valid[c] = 1'b1;
                in_startofpacket[c] = b.sop;
                in_endofpacket[c] = b.eop;
                in_error[c] = b.err;
                in_data[c*W +: W] = b.data;
                in_empty[c*EW +: EW] = b.empty;
            end
        end
        ch_enable = en;
        case (rdy_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ($urandom_range(0, 3) != 0);
            default: out_ready = 1'b0;
        endcase
    endtask

    // ---------------------------------------------------------- monitor
    task automatic sample();
        beat_t obs;
        int ch;
        s_in_ready = in_ready;
        s_out_valid = out_valid;
        for (int c = 0; c < NUM_CH; c++) begin
            if (in_valid[c] && in_ready[c]) begin
                void'(drv_q[c].pop_front());
                pres[c] = 1'b0;
                acc_cnt[c]++;
            end
        end
        obs = {out_startofpacket, out_endofpacket, out_error, out_empty, out_data};
        if (prev_stall && !prev_rst && !rst) begin
            check("hold_valid", out_valid, 1'b1);
            check("hold_beat", obs, prev_obs);
            check("hold_channel", out_channel, prev_ch);
        end
        prev_stall = out_valid && !out_ready;
        prev_obs = obs;
        prev_ch = out_channel;
        prev_rst = rst;
        if (out_valid && out_ready) begin
            ch = int'(out_channel);
            if (pkt_open) check("atomic_channel", ch, open_ch);
            check("beat_expected", exp_q[ch].size() > 0, 1'b1);
            if (exp_q[ch].size() > 0) check("beat", obs, exp_q[ch].pop_front());
            log_ch.push_back(ch);
            log_cyc.push_back(cyc);
            if (obs.sop) begin
                pkt_order.push_back(ch);
                pkt_open = 1'b1;
                open_ch = ch;
            end
            if (obs.eop) pkt_open = 1'b0;
        end
    endtask

    task automatic cycle();
        drive();
        #1;
        sample();
        @(negedge clk);
        cyc++;
    endtask

    function automatic logic all_empty();
        logic e;
        e = 1'b1;
        for (int c = 0; c < NUM_CH; c++) begin
            if (drv_q[c].size() != 0 || exp_q[c].size() != 0) e = 1'b0;
        end
        return e;
    endfunction

    task automatic drain(input string tag, input int budget);
        int n;
        logic done;
        n = 0;
        done = 1'b0;
        while (!done && n < budget) begin
            cycle();
            n++;
            done = !s_out_valid && all_empty();
        end
        check(tag, done, 1'b1);
    endtask

    task automatic check_counters(input string tag);
        for (int c = 0; c < NUM_CH; c++) begin
            check($sformatf("%s_pkt_count%0d", tag, c), pkt_count[c*CW +: CW], exp_pkt[c]);
        end
        check({tag, "_drop_count"}, drop_count, exp_drop);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) cycle();
        rst = 1'b0;
        model_reset();
    endtask

    // ---------------------------------------------------------- sequence
    initial begin
        int n;
        int base_acc;
        int len;
        int stray;
        for (int c = 0; c < NUM_CH; c++) begin
            pres[c] = 1'b0;
            acc_cnt[c] = 0;
        end
        model_reset();

        // Reset state
        repeat (3) cycle();
        rst = 1'b0;
        drive();
        #1;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_in_ready", in_ready, '0);
        check("rst_out_fields", {out_startofpacket, out_endofpacket, out_error, out_empty, out_data, out_channel}, '0);
        check("rst_state", dbg_state, 1'b0);
        check("rst_rr_ptr", dbg_rr_ptr, 2'd0);
        check_counters("rst");
        @(negedge clk);
        cyc++;

        // T1: ch0 and ch2 start together; ch0 first, one idle gap, then ch2
        log_ch.delete();
        log_cyc.delete();
        gen_pkt(0, 3, -1, 64'h1000);
        gen_pkt(2, 3, -1, 64'h2000);
        drain("t1_drain", 100);
        check("t1_beats", log_ch.size(), 6);
        if (log_ch.size() == 6) begin
            for (int i = 0; i < 6; i++) check($sformatf("t1_ch%0d", i), log_ch[i], (i < 3) ? 0 : 2);
            check("t1_b2b", log_cyc[1] - log_cyc[0], 1);
            check("t1_gap", log_cyc[3] - log_cyc[2], 2);
        end
        check("t1_rr_ptr", dbg_rr_ptr, 2'd3);
        check_counters("t1");

        // T2: ch1 and ch3 both stream 2-beat packets -> strict alternation
        do_reset();
        pkt_order.delete();
        for (int i = 0; i < 3; i++) begin
            gen_pkt(1, 2, -1, 64'h3100 + 64'(i * 16));
            gen_pkt(3, 2, -1, 64'h3300 + 64'(i * 16));
        end
        drain("t2_drain", 200);
        check("t2_pkts", pkt_order.size(), 6);
        if (pkt_order.size() == 6) begin
            for (int i = 0; i < 6; i++) check($sformatf("t2_order%0d", i), pkt_order[i], (i % 2 == 0) ? 1 : 3);
        end
        check_counters("t2");

        // T3: output stalled for 5 cycles mid-packet on ch0
        log_ch.delete();
        gen_pkt(0, 6, -1, 64'h4000);
        n = 0;
        while (log_ch.size() < 2 && n < 50) begin
            cycle();
            n++;
        end
        check("t3_reach", log_ch.size() >= 2, 1'b1);
        rdy_mode = 2;
        for (int i = 0; i < 5; i++) begin
            cycle();
            check("t3_in_ready0", s_in_ready[0], 1'b0);
            check("t3_out_valid", s_out_valid, 1'b1);
        end
        rdy_mode = 0;
        drain("t3_drain", 100);
        check("t3_beats", log_ch.size(), 6);
        check_counters("t3");

        // T4: disabled channel is drained; enable dropped mid-packet completes
        en[2] = 1'b0;
        gen_pkt(2, 4, -1, 64'h5000);
        drain("t4a_drain", 100);
        check_counters("t4a");
        en[2] = 1'b1;
        gen_pkt(1, 6, -1, 64'h5100);
        base_acc = acc_cnt[1];
        n = 0;
        while (acc_cnt[1] - base_acc < 2 && n < 50) begin
            cycle();
            n++;
        end
        en[1] = 1'b0;
        drain("t4b_drain", 100);
        check_counters("t4b");
        en[1] = 1'b1;

        // T5: stray SOP inside a ch0 packet (data A, B, C)
        gen_pkt(0, 3, 1, 64'hA);
        drain("t5_drain", 100);
        check_counters("t5");

        // T6: reset while the 2nd beat of a 4-beat ch0 packet transfers
        do_reset();
        gen_pkt(0, 4, -1, 64'h600);
        repeat (3) void'(exp_q[0].pop_back());
        base_acc = acc_cnt[0];
        n = 0;
        while (acc_cnt[0] - base_acc < 1 && n < 50) begin
            cycle();
            n++;
        end
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        model_reset();
        check("t6_out_valid", out_valid, 1'b0);
        check_counters("t6_rst");
        exp_drop = CW'(2);
        drain("t6_drain", 100);
        check_counters("t6");

        // Random: mixed enables, lengths, stray SOPs, gaps and backpressure
        do_reset();
        en = NUM_CH'($urandom_range(0, 15)) | 4'b0001;
        go_pct = 60;
        rdy_mode = 1;
        for (int i = 0; i < 40; i++) begin
            len = $urandom_range(1, 5);
            stray = (len > 1 && $urandom_range(0, 4) == 0) ? $urandom_range(1, len - 1) : -1;
            gen_pkt($urandom_range(0, NUM_CH - 1), len, stray, {$urandom, $urandom});
        end
        drain("rand_drain", 5000);
        check_counters("rand");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
